// File: rtl/spi_slave_port.sv
// Mode-0, MSB-first SPI slave with oversampled pins, a one-word tx holding register
// and a valid/ready receive port.
module spi_slave_port #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_CE,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   ce_hist_q, ce_hist_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   spi_miso_q, spi_miso_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   reload_pending_q, reload_pending_d;
    logic                   rise_defer_q, rise_defer_d;

    logic sck_s, mosi_s, ce_s;
    logic sck_rise, sck_fall, ce_rise, ce_fall;
    logic do_reload;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ce_s     = ce_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign ce_rise  = ce_s & ~ce_hist_q;
    assign ce_fall  = ~ce_s & ce_hist_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        ce_sync_d   = {ce_sync_q[SYNC_STAGES-2:0], spi_CE};
        sck_hist_d  = sck_s;
        ce_hist_d   = ce_s;
    end

    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        hold_d           = hold_q;
        hold_valid_d     = hold_valid_q;
        rx_data_d        = rx_data_q;
        rx_valid_d       = rx_valid_q;
        rx_overrun_d     = 1'b0;
        tx_underrun_d    = 1'b0;
        spi_miso_d       = spi_miso_q;
        bit_cnt_d        = bit_cnt_q;
        reload_pending_d = reload_pending_q;
        rise_defer_d     = 1'b0;
        do_reload        = 1'b0;

        if (tx_valid && !hold_valid_q) begin
            hold_d       = tx_data;
            hold_valid_d = 1'b1;
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ce_fall) begin
                    state_d          = ACTIVE;
                    bit_cnt_d        = '0;
                    reload_pending_d = 1'b0;
                    do_reload        = 1'b1;
                    // A rise coinciding with CE fall is replayed on the next cycle.
                    rise_defer_d     = sck_rise;
                end
            end
            ACTIVE: begin
                if (ce_rise) begin
                    state_d          = IDLE;
                    bit_cnt_d        = '0;
                    reload_pending_d = 1'b0;
                    spi_miso_d       = 1'b1;
                end else if (sck_rise || rise_defer_q) begin
                    shift_d = {shift_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d        = {shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d       = 1'b1;
                        rx_overrun_d     = rx_valid_q & ~rx_ready;
                        bit_cnt_d        = '0;
                        reload_pending_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    if (reload_pending_q) begin
                        do_reload        = 1'b1;
                        reload_pending_d = 1'b0;
                    end else begin
                        spi_miso_d = shift_q[DATA_W-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload uses the registered holding word; a word offered this cycle waits.
        if (do_reload) begin
            if (hold_valid_q) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
            end else begin
                shift_d       = IDLE_WORD;
                tx_underrun_d = 1'b1;
            end
            spi_miso_d = shift_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            sck_sync_q       <= '0;
            mosi_sync_q      <= '0;
            ce_sync_q        <= '1;
            sck_hist_q       <= 1'b0;
            ce_hist_q        <= 1'b1;
            shift_q          <= '0;
            hold_q           <= '0;
            hold_valid_q     <= 1'b0;
            rx_data_q        <= '0;
            rx_valid_q       <= 1'b0;
            rx_overrun_q     <= 1'b0;
            tx_underrun_q    <= 1'b0;
            spi_miso_q       <= 1'b1;
            bit_cnt_q        <= '0;
            reload_pending_q <= 1'b0;
            rise_defer_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sck_sync_q       <= sck_sync_d;
            mosi_sync_q      <= mosi_sync_d;
            ce_sync_q        <= ce_sync_d;
            sck_hist_q       <= sck_hist_d;
            ce_hist_q        <= ce_hist_d;
            shift_q          <= shift_d;
            hold_q           <= hold_d;
            hold_valid_q     <= hold_valid_d;
            rx_data_q        <= rx_data_d;
            rx_valid_q       <= rx_valid_d;
            rx_overrun_q     <= rx_overrun_d;
            tx_underrun_q    <= tx_underrun_d;
            spi_miso_q       <= spi_miso_d;
            bit_cnt_q        <= bit_cnt_d;
            reload_pending_q <= reload_pending_d;
            rise_defer_q     <= rise_defer_d;
        end
    end

    assign spi_miso    = spi_miso_q;
    assign spi_miso_oe = ~ce_s;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_ready    = ~hold_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a bit-banged mode-0 master at clk/10 plus
// a table of single-word frames and hand-written multi-word corner sequences.
module tb_spi_slave_port;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk, spi_mosi, spi_ce;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_underrun, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_under = 0;
    int n_over = 0;
    int n_rv = 0;
    logic rv_prev = 1'b0;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         queue;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_under;
    } vec_t;
    vec_t vecs[5];

    spi_slave_port #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_CE(spi_ce),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_underrun) n_under++;
        if (rx_overrun) n_over++;
        if (rx_valid && !rv_prev) n_rv++;
        rv_prev = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tx_push(input logic [7:0] w);
        bit done;
        done = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (tx_ready) done = 1;
            tick(1);
        end
        tx_valid = 1'b0;
        if (!done) chk("tx_push_timeout", 32'd0, 32'd1);
    endtask

    task automatic rx_consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("rx_valid_after_consume", rx_valid, 0);
    endtask

    // Master bit loop; the closing SCK fall of a frame coincides with CE rise.
    task automatic send_bits(input logic [7:0] w, input int nbits, input bit end_frame,
                             output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[7-i];
            tick(HALF);
            got = {got[6:0], spi_miso};
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
            if (end_frame && i == nbits - 1) spi_ce = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] g, g2;
        int u0, o0, r0;

        vecs[0] = '{8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5, 0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 0};
        vecs[2] = '{8'h5A, 8'h00, 1'b0, 8'h5A, 8'hFF, 1};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h80, 8'h01, 0};
        vecs[4] = '{8'h01, 8'h80, 1'b1, 8'h01, 8'h80, 0};

        rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_ce = 1'b1;
        rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        tick(3);
        chk("rst_miso", spi_miso, 1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {rx_overrun, tx_underrun}, 0);
        rst = 1'b0;
        tick(2);

        // SCK activity with CE high
        for (int i = 0; i < 20; i++) begin
            spi_clk = 1'b1; tick(HALF);
            spi_clk = 1'b0; tick(HALF);
        end
        tick(4);
        chk("ce_high_rx_valid", rx_valid, 0);
        chk("ce_high_busy", busy, 0);
        chk("ce_high_miso", spi_miso, 1);
        chk("ce_high_pulses", n_under + n_over, 0);

        // Single-word frames
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].queue) tx_push(vecs[v].tx);
            u0 = n_under; o0 = n_over;
            spi_ce = 1'b0;
            tick(6);
            chk($sformatf("v%0d_busy", v), busy, 1);
            chk($sformatf("v%0d_oe", v), spi_miso_oe, 1);
            chk($sformatf("v%0d_tx_ready", v), tx_ready, 1);
            send_bits(vecs[v].mosi, 8, 1'b1, g);
            tick(8);
            chk($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            chk($sformatf("v%0d_rx_valid", v), rx_valid, 1);
            chk($sformatf("v%0d_miso_word", v), g, vecs[v].exp_miso);
            chk($sformatf("v%0d_underruns", v), n_under - u0, vecs[v].exp_under);
            chk($sformatf("v%0d_overruns", v), n_over - o0, 0);
            chk($sformatf("v%0d_idle", v), {busy, spi_miso, spi_miso_oe}, 3'b010);
            rx_consume();
        end

        // Two words, nothing queued, rx not consumed
        u0 = n_under; o0 = n_over;
        spi_ce = 1'b0;
        tick(6);
        send_bits(8'h01, 8, 1'b0, g);
        send_bits(8'h02, 8, 1'b1, g2);
        tick(8);
        chk("two_w_miso1", g, 8'hFF);
        chk("two_w_miso2", g2, 8'hFF);
        chk("two_w_underruns", n_under - u0, 2);
        chk("two_w_overruns", n_over - o0, 1);
        chk("two_w_rx_data", rx_data, 8'h02);
        rx_consume();

        // Partial frame discarded, then a full frame
        r0 = n_rv;
        spi_ce = 1'b0;
        tick(6);
        send_bits(8'hF0, 5, 1'b1, g);
        tick(10);
        chk("partial_rx_valid", rx_valid, 0);
        spi_ce = 1'b0;
        tick(6);
        send_bits(8'h81, 8, 1'b1, g);
        tick(8);
        chk("after_partial_rx_data", rx_data, 8'h81);
        chk("after_partial_rv_count", n_rv - r0, 1);
        rx_consume();

        // Back-to-back words, second tx word offered while reload is pending
        tx_push(8'h55);
        u0 = n_under;
        spi_ce = 1'b0;
        tick(6);
        send_bits(8'h12, 7, 1'b0, g);
        spi_mosi = 1'b0;
        tick(HALF);
        g = {g[6:0], spi_miso};
        spi_clk = 1'b1;
        tick(HALF - 1);
        tx_push(8'hAA);
        spi_clk = 1'b0;
        send_bits(8'h34, 8, 1'b1, g2);
        tick(8);
        chk("b2b_miso1", g, 8'h55);
        chk("b2b_miso2", g2, 8'hAA);
        chk("b2b_underruns", n_under - u0, 0);
        chk("b2b_rx_data", rx_data, 8'h34);
        rx_consume();

        // Reset mid-frame with a tx word queued
        spi_ce = 1'b0;
        tick(6);
        tx_push(8'h99);
        chk("mid_tx_ready_full", tx_ready, 0);
        send_bits(8'hC3, 4, 1'b0, g);
        rst = 1'b1;
        spi_ce = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
        chk("post_rst_tx_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rx_valid", rx_valid, 0);
        u0 = n_under;
        spi_ce = 1'b0;
        tick(6);
        send_bits(8'h7E, 8, 1'b1, g);
        tick(8);
        chk("post_rst_miso", g, 8'hFF);
        chk("post_rst_underruns", n_under - u0, 1);
        chk("post_rst_rx_data", rx_data, 8'h7E);
        chk("post_rst_rx_valid2", rx_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
